// File: rtl/valid_ready_multiport_out_of_order_buffer_first_one.sv
// first_one: lowest-set-bit encoder.
// Reports the position of the least significant set bit of vec. index is 0
// and found is low when no bit is set.
module first_one #(
    parameter int WIDTH       = 8,
    parameter int INDEX_WIDTH = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]       vec,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   found
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                index = INDEX_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/valid_ready_multiport_out_of_order_buffer.sv
// valid_ready_multiport_out_of_order_buffer
// Indexed out-of-order buffer. A write takes the lowest free entry and
// reports that entry's index. Any read port can read an allocated entry by
// index, with no latency, and can optionally free it.
// Optional feature: define OUT_OF_ORDER_BUFFER_OCCUPANCY_EN to add a
// registered occupancy count output.
module valid_ready_multiport_out_of_order_buffer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int READ_PORTS  = 2,
    parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
    input  logic                              clock,
    input  logic                              resetn,
    output logic                              full,
    output logic                              empty,
    input  logic                              write_valid,
    input  logic [WIDTH-1:0]                  write_data,
    output logic [INDEX_WIDTH-1:0]            write_index,
    output logic                              write_ready,
    input  logic [READ_PORTS-1:0]             read_valid,
    input  logic [READ_PORTS-1:0]             read_clear,
    input  logic [READ_PORTS*INDEX_WIDTH-1:0] read_index,
    output logic [READ_PORTS*WIDTH-1:0]       read_data,
    output logic [READ_PORTS-1:0]             read_ready,
    output logic [READ_PORTS-1:0]             read_error
`ifdef OUT_OF_ORDER_BUFFER_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]        occupancy
`endif
);

    // Index space can be larger than DEPTH; lookups go through a zero-padded
    // copy of the allocation vector so out-of-range indices read as free.
    localparam int EXT_DEPTH = 1 << INDEX_WIDTH;

    logic [DEPTH-1:0]       alloc_q;
    logic [DEPTH-1:0]       alloc_d;
    logic [DEPTH-1:0]       free_vec;
    logic [DEPTH-1:0]       clear_mask;
    logic [EXT_DEPTH-1:0]   alloc_ext;
    logic [EXT_DEPTH-1:0]   clear_ext;
    logic [WIDTH-1:0]       mem [DEPTH];
    logic [INDEX_WIDTH-1:0] rd_idx [READ_PORTS];
    logic [INDEX_WIDTH-1:0] free_index;
    logic                   free_found;
    logic                   wr_accept;

    assign free_vec    = ~alloc_q;
    assign full        = &alloc_q;
    assign empty       = ~|alloc_q;
    assign write_ready = ~full;
    assign write_index = free_found ? free_index : '0;
    assign wr_accept   = write_valid & write_ready;
    assign read_ready  = '1;
    assign clear_mask  = clear_ext[DEPTH-1:0];

    first_one #(
        .WIDTH       (DEPTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_first_one (
        .vec   (free_vec),
        .index (free_index),
        .found (free_found)
    );

    // Split the packed per-port read indices.
    always_comb begin
        for (int p = 0; p < READ_PORTS; p++) begin
            rd_idx[p] = read_index[p*INDEX_WIDTH +: INDEX_WIDTH];
        end
    end

    // Read muxes, error flags and the set of entries freed by clearing reads.
    // Several ports clearing the same entry simply set the same mask bit.
    always_comb begin
        alloc_ext              = '0;
        alloc_ext[DEPTH-1:0]   = alloc_q;
        clear_ext              = '0;
        read_data              = '0;
        read_error             = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (read_valid[p]) begin
                if (alloc_ext[rd_idx[p]]) begin
                    read_data[p*WIDTH +: WIDTH] = mem[rd_idx[p]];
                    if (read_clear[p]) begin
                        clear_ext[rd_idx[p]] = 1'b1;
                    end
                end else begin
                    read_error[p] = 1'b1;
                end
            end
        end
    end

    // Next allocation vector: frees and the new write land on the same edge.
    // The write target is never a cleared entry since it is currently free.
    always_comb begin
        alloc_d = alloc_q & ~clear_mask;
        if (wr_accept) begin
            alloc_d[write_index] = 1'b1;
        end
    end

    // Allocation state; reset discards every entry.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            alloc_q <= '0;
        end else begin
            alloc_q <= alloc_d;
        end
    end

    // Payload storage, deliberately not reset; clears leave the data alone.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[write_index] <= write_data;
        end
    end

`ifdef OUT_OF_ORDER_BUFFER_OCCUPANCY_EN
    logic [$clog2(DEPTH+1)-1:0] occ_d;

    // Population count of the next allocation vector.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + $bits(occ_d)'(alloc_d[i]);
        end
    end

    // Registered occupancy, tracking the allocation vector edge for edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_d;
        end
    end
`endif

endmodule

// File: tb/tb_valid_ready_multiport_out_of_order_buffer.sv
// Directed bench for valid_ready_multiport_out_of_order_buffer
// (default parameters; occupancy checks follow OUT_OF_ORDER_BUFFER_OCCUPANCY_EN).
module tb_valid_ready_multiport_out_of_order_buffer;

    logic        clock;
    logic        resetn;
    logic        full;
    logic        empty;
    logic        write_valid;
    logic [7:0]  write_data;
    logic [2:0]  write_index;
    logic        write_ready;
    logic [1:0]  read_valid;
    logic [1:0]  read_clear;
    logic [5:0]  read_index;
    logic [15:0] read_data;
    logic [1:0]  read_ready;
    logic [1:0]  read_error;
`ifdef OUT_OF_ORDER_BUFFER_OCCUPANCY_EN
    logic [3:0]  occupancy;
`endif

    int n_cmp = 0;
    int n_err = 0;

    valid_ready_multiport_out_of_order_buffer dut (
        .clock       (clock),
        .resetn      (resetn),
        .full        (full),
        .empty       (empty),
        .write_valid (write_valid),
        .write_data  (write_data),
        .write_index (write_index),
        .write_ready (write_ready),
        .read_valid  (read_valid),
        .read_clear  (read_clear),
        .read_index  (read_index),
        .read_data   (read_data),
        .read_ready  (read_ready),
        .read_error  (read_error)
`ifdef OUT_OF_ORDER_BUFFER_OCCUPANCY_EN
        ,
        .occupancy   (occupancy)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        write_valid = 1'b0;
        write_data  = 8'h00;
        read_valid  = 2'b00;
        read_clear  = 2'b00;
        read_index  = 6'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn = 1'b0;
        #13;
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
        n_cmp++; if (write_ready !== 1'b1) begin n_err++; $display("FAIL reset_write_ready got %b want 1", write_ready); end
        n_cmp++; if (write_index !== 3'd0) begin n_err++; $display("FAIL reset_write_index got %0d want 0", write_index); end
        n_cmp++; if (read_error !== 2'b00) begin n_err++; $display("FAIL reset_read_error got %b want 00", read_error); end
        n_cmp++; if (read_data !== 16'h0000) begin n_err++; $display("FAIL reset_read_data got %h want 0000", read_data); end
        n_cmp++; if (read_ready !== 2'b11) begin n_err++; $display("FAIL reset_read_ready got %b want 11", read_ready); end
`ifdef OUT_OF_ORDER_BUFFER_OCCUPANCY_EN
        n_cmp++; if (occupancy !== 4'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
`endif
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_empty_read();
        read_valid = 2'b01;
        read_clear = 2'b01;
        read_index = {3'd0, 3'd2};
        #1;
        n_cmp++; if (read_error !== 2'b01) begin n_err++; $display("FAIL empty_read_error got %b want 01", read_error); end
        n_cmp++; if (read_data[7:0] !== 8'h00) begin n_err++; $display("FAIL empty_read_data got %h want 00", read_data[7:0]); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL empty_stays_empty got %b want 1", empty); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            write_valid = 1'b1;
            write_data  = 8'h10 + 8'(i);
            #1;
            n_cmp++; if (write_index !== 3'(i)) begin n_err++; $display("FAIL fill_index[%0d] got %0d want %0d", i, write_index, i); end
            n_cmp++; if (write_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d] got %b want 1", i, write_ready); end
            tick();
        end
        write_data = 8'h99;
        #1;
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b want 1", full); end
        n_cmp++; if (write_ready !== 1'b0) begin n_err++; $display("FAIL fill_write_ready got %b want 0", write_ready); end
        n_cmp++; if (write_index !== 3'd0) begin n_err++; $display("FAIL fill_full_index got %0d want 0", write_index); end
        tick();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            read_valid = 2'b11;
            read_index = {3'(7 - i), 3'(i)};
            #1;
            n_cmp++; if (read_data[7:0] !== 8'h10 + 8'(i)) begin n_err++; $display("FAIL fill_readback_p0[%0d] got %h want %h", i, read_data[7:0], 8'h10 + 8'(i)); end
            n_cmp++; if (read_data[15:8] !== 8'h17 - 8'(i)) begin n_err++; $display("FAIL fill_readback_p1[%0d] got %h want %h", i, read_data[15:8], 8'h17 - 8'(i)); end
        end
        idle_inputs();
`ifdef OUT_OF_ORDER_BUFFER_OCCUPANCY_EN
        n_cmp++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL fill_occupancy got %0d want 8", occupancy); end
`endif
    endtask

    task automatic test_clear_refill();
        read_valid = 2'b01;
        read_clear = 2'b01;
        read_index = {3'd0, 3'd3};
        #1;
        n_cmp++; if (read_data[7:0] !== 8'h13) begin n_err++; $display("FAIL clr_read_data got %h want 13", read_data[7:0]); end
        n_cmp++; if (read_error !== 2'b00) begin n_err++; $display("FAIL clr_read_error got %b want 00", read_error); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (write_index !== 3'd3) begin n_err++; $display("FAIL clr_next_index got %0d want 3", write_index); end
        n_cmp++; if (write_ready !== 1'b1) begin n_err++; $display("FAIL clr_next_ready got %b want 1", write_ready); end
        write_valid = 1'b1;
        write_data  = 8'hAA;
        tick();
        idle_inputs();
        read_valid = 2'b01;
        read_index = {3'd0, 3'd3};
        #1;
        n_cmp++; if (read_data[7:0] !== 8'hAA) begin n_err++; $display("FAIL clr_refill_data got %h want aa", read_data[7:0]); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL clr_refill_full got %b want 1", full); end
        idle_inputs();
    endtask

    task automatic test_multi_read();
        read_valid = 2'b11;
        read_clear = 2'b10;
        read_index = {3'd5, 3'd5};
        #1;
        n_cmp++; if (read_data !== 16'h1515) begin n_err++; $display("FAIL multi_data got %h want 1515", read_data); end
        n_cmp++; if (read_error !== 2'b00) begin n_err++; $display("FAIL multi_error got %b want 00", read_error); end
        tick();
        idle_inputs();
        read_valid = 2'b01;
        read_index = {3'd0, 3'd5};
        #1;
        n_cmp++; if (read_error !== 2'b01) begin n_err++; $display("FAIL multi_after_error got %b want 01", read_error); end
        n_cmp++; if (read_data[7:0] !== 8'h00) begin n_err++; $display("FAIL multi_after_data got %h want 00", read_data[7:0]); end
        n_cmp++; if (write_index !== 3'd5) begin n_err++; $display("FAIL multi_free_index got %0d want 5", write_index); end
        idle_inputs();
        write_valid = 1'b1;
        write_data  = 8'h25;
        tick();
        idle_inputs();
    endtask

    task automatic test_full_write_clear();
        read_valid  = 2'b01;
        read_clear  = 2'b01;
        read_index  = {3'd0, 3'd0};
        write_valid = 1'b1;
        write_data  = 8'h55;
        #1;
        n_cmp++; if (write_ready !== 1'b0) begin n_err++; $display("FAIL fwc_ready_in_clear got %b want 0", write_ready); end
        n_cmp++; if (read_data[7:0] !== 8'h10) begin n_err++; $display("FAIL fwc_old_data got %h want 10", read_data[7:0]); end
        tick();
        read_valid = 2'b00;
        read_clear = 2'b00;
        #1;
        n_cmp++; if (write_ready !== 1'b1) begin n_err++; $display("FAIL fwc_ready_next got %b want 1", write_ready); end
        n_cmp++; if (write_index !== 3'd0) begin n_err++; $display("FAIL fwc_index_next got %0d want 0", write_index); end
`ifdef OUT_OF_ORDER_BUFFER_OCCUPANCY_EN
        n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL fwc_occupancy_7 got %0d want 7", occupancy); end
`endif
        tick();
        idle_inputs();
        read_valid = 2'b01;
        read_index = {3'd0, 3'd0};
        #1;
        n_cmp++; if (read_data[7:0] !== 8'h55) begin n_err++; $display("FAIL fwc_new_data got %h want 55", read_data[7:0]); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fwc_full got %b want 1", full); end
`ifdef OUT_OF_ORDER_BUFFER_OCCUPANCY_EN
        n_cmp++; if (occupancy !== 4'd8) begin n_err++; $display("FAIL fwc_occupancy_8 got %0d want 8", occupancy); end
`endif
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        read_valid = 2'b01;
        read_clear = 2'b01;
        read_index = {3'd0, 3'd2};
        tick();
        read_index  = {3'd0, 3'd4};
        write_valid = 1'b1;
        write_data  = 8'h62;
        #1;
        n_cmp++; if (write_index !== 3'd2) begin n_err++; $display("FAIL b2b_index_2 got %0d want 2", write_index); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (write_index !== 3'd4) begin n_err++; $display("FAIL b2b_index_4 got %0d want 4", write_index); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL b2b_not_full got %b want 0", full); end
`ifdef OUT_OF_ORDER_BUFFER_OCCUPANCY_EN
        n_cmp++; if (occupancy !== 4'd7) begin n_err++; $display("FAIL b2b_occupancy got %0d want 7", occupancy); end
`endif
        write_valid = 1'b1;
        write_data  = 8'h64;
        tick();
        idle_inputs();
        read_valid = 2'b11;
        read_index = {3'd4, 3'd2};
        #1;
        n_cmp++; if (read_data !== 16'h6462) begin n_err++; $display("FAIL b2b_data got %h want 6462", read_data); end
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL b2b_full got %b want 1", full); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            write_valid = 1'b1;
            write_data  = 8'h40 + 8'(i);
            tick();
        end
        idle_inputs();
        #1;
        n_cmp++; if (write_index !== 3'd4) begin n_err++; $display("FAIL rmid_pre_index got %0d want 4", write_index); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rmid_empty got %b want 1", empty); end
        n_cmp++; if (write_index !== 3'd0) begin n_err++; $display("FAIL rmid_index got %0d want 0", write_index); end
        tick();
        resetn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            read_valid = 2'b11;
            read_index = {3'(i), 3'(i)};
            #1;
            n_cmp++; if (read_error !== 2'b11) begin n_err++; $display("FAIL rmid_read_error[%0d] got %b want 11", i, read_error); end
            n_cmp++; if (read_data !== 16'h0000) begin n_err++; $display("FAIL rmid_read_data[%0d] got %h want 0000", i, read_data); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_empty_read();
        test_fill();
        test_clear_refill();
        test_multi_read();
        test_full_write_clear();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
